// File: rtl/bus_pkg.sv
// Shared encodings for the two-requester pad bus controller.
package bus_pkg;

   localparam logic [1:0] SZ_BYTE  = 2'd0;
   localparam logic [1:0] SZ_HALF  = 2'd1;
   localparam logic [1:0] SZ_WORD  = 2'd2;
   localparam logic [1:0] SZ_DWORD = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      OWN_FETCH = 1'b0,
      OWN_LS    = 1'b1
   } owner_e;

endpackage

// File: rtl/bus_arb_ctrl_if.sv
// Requester and pad-bus signals of bus_arb_ctrl; master is the controller side.
interface bus_arb_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic                    ld_on_rst;
   logic                    f_req;
   logic [ADDR_WIDTH-1:0]   f_addr;
   logic                    f_gnt;
   logic                    f_rvalid;
   logic [DATA_WIDTH-1:0]   f_rdata;
   logic                    f_err;
   logic                    ls_req;
   logic                    ls_we;
   logic [1:0]              ls_size;
   logic [ADDR_WIDTH-1:0]   ls_addr;
   logic [DATA_WIDTH-1:0]   ls_wdata;
   logic                    ls_gnt;
   logic                    ls_rvalid;
   logic [DATA_WIDTH-1:0]   ls_rdata;
   logic                    ls_err;
   logic [ADDR_WIDTH-1:0]   o_last_addr;
   logic                    o_bus_en;
   logic                    o_bus_we;
   logic [ADDR_WIDTH-1:0]   o_bus_addr;
   logic [1:0]              o_bus_size;
   logic [DATA_WIDTH/8-1:0] o_bus_be;
   logic [DATA_WIDTH-1:0]   o_bus_st_data;
   logic                    i_bus_ready;
   logic [DATA_WIDTH-1:0]   i_bus_ld_data;

   modport master (
      input  ld_on_rst, f_req, f_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             i_bus_ready, i_bus_ld_data,
      output f_gnt, f_rvalid, f_rdata, f_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             o_last_addr, o_bus_en, o_bus_we, o_bus_addr, o_bus_size, o_bus_be, o_bus_st_data
   );

   modport slave (
      output ld_on_rst, f_req, f_addr, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             i_bus_ready, i_bus_ld_data,
      input  f_gnt, f_rvalid, f_rdata, f_err, ls_gnt, ls_rvalid, ls_rdata, ls_err,
             o_last_addr, o_bus_en, o_bus_we, o_bus_addr, o_bus_size, o_bus_be, o_bus_st_data
   );
endinterface

// File: rtl/bus_lane_align.sv
// Byte-lane aligner: size/offset to byte enables, store replication,
// load extraction and misalignment flag. Purely combinational.
module bus_lane_align
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [1:0]                      size_i,
   input  logic [$clog2(DATA_WIDTH/8)-1:0] off_i,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   input  logic [DATA_WIDTH-1:0]           ld_data_i,
   output logic [DATA_WIDTH/8-1:0]         be_o,
   output logic [DATA_WIDTH-1:0]           st_data_o,
   output logic [DATA_WIDTH-1:0]           ld_data_o,
   output logic                            misalign_o
);
   localparam int NB = DATA_WIDTH / 8;

   logic [2:0]            off3;
   logic [DATA_WIDTH-1:0] shifted;

   always_comb begin
      off3       = 3'(off_i);
      shifted    = ld_data_i >> {off_i, 3'b000};
      be_o       = '1;
      st_data_o  = wdata_i;
      ld_data_o  = shifted;
      misalign_o = 1'b0;
      case (size_i)
         SZ_BYTE: begin
            be_o      = NB'(1) << off_i;
            st_data_o = {(DATA_WIDTH/8){wdata_i[7:0]}};
            ld_data_o = DATA_WIDTH'(shifted[7:0]);
         end
         SZ_HALF: begin
            be_o       = NB'(3) << off_i;
            st_data_o  = {(DATA_WIDTH/16){wdata_i[15:0]}};
            ld_data_o  = DATA_WIDTH'(shifted[15:0]);
            misalign_o = off3[0];
         end
         SZ_WORD: begin
            misalign_o = (off3[1:0] != 2'b00);
            // on a 32-bit bus a word is already full width
            if (DATA_WIDTH == 64) begin
               be_o      = NB'(4'hF) << off_i;
               st_data_o = {(DATA_WIDTH/32){wdata_i[31:0]}};
               ld_data_o = DATA_WIDTH'(shifted[31:0]);
            end
         end
         default: begin
            misalign_o = (DATA_WIDTH == 32) || (off3 != 3'b000);
         end
      endcase
   end
endmodule

// File: rtl/bus_arb_ctrl.sv
// Two-requester (fetch, load/store) pad bus controller with round-robin or
// fixed-priority arbitration, lane alignment, timeout and error responses.
module bus_arb_ctrl
   import bus_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 16,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int FETCH_PRIO     = 0
) (
   input  logic           clk_i,
   input  logic           reset_n,
   bus_arb_ctrl_if.master bif
);
   localparam int         NB      = DATA_WIDTH / 8;
   localparam int         OFF_W   = $clog2(NB);
   localparam int         CNT_W   = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] SZ_FULL = (DATA_WIDTH == 64) ? SZ_DWORD : SZ_WORD;

   state_e                state_q, state_d;
   owner_e                owner_q, owner_d, rr_q, rr_d;
   logic [1:0]            size_q, size_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
   logic                  bus_en_q, bus_en_d, bus_we_q, bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
   logic [1:0]            bus_size_q, bus_size_d;
   logic [NB-1:0]         bus_be_q, bus_be_d;
   logic [DATA_WIDTH-1:0] bus_st_q, bus_st_d;

   logic                  pick_f, pick_ls, sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [1:0]            sel_size;
   logic [OFF_W-1:0]      sel_off;
   logic [DATA_WIDTH-1:0] sel_wdata, req_st, rsp_ld;
   logic [NB-1:0]         req_be;
   logic                  req_mis;
   logic [DATA_WIDTH-1:0] unused_req_ld, unused_rsp_st;
   logic [NB-1:0]         unused_rsp_be;
   logic                  unused_rsp_mis;

   // fetch is always a full-width access at lane offset 0
   assign pick_f    = bif.f_req && !bif.ld_on_rst &&
                      (!bif.ls_req || (FETCH_PRIO != 0) || (rr_q == OWN_FETCH));
   assign pick_ls   = bif.ls_req && !pick_f;
   assign sel_addr  = pick_f ? bif.f_addr : bif.ls_addr;
   assign sel_size  = pick_f ? SZ_FULL : bif.ls_size;
   assign sel_off   = pick_f ? '0 : bif.ls_addr[OFF_W-1:0];
   assign sel_we    = pick_f ? 1'b0 : bif.ls_we;
   assign sel_wdata = pick_f ? '0 : bif.ls_wdata;

   bus_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_req_align (
      .size_i(sel_size), .off_i(sel_off), .wdata_i(sel_wdata), .ld_data_i('0),
      .be_o(req_be), .st_data_o(req_st), .ld_data_o(unused_req_ld), .misalign_o(req_mis)
   );

   bus_lane_align #(.DATA_WIDTH(DATA_WIDTH)) u_rsp_align (
      .size_i(size_q), .off_i(off_q), .wdata_i('0), .ld_data_i(bif.i_bus_ld_data),
      .be_o(unused_rsp_be), .st_data_o(unused_rsp_st), .ld_data_o(rsp_ld),
      .misalign_o(unused_rsp_mis)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      rr_d        = rr_q;
      size_d      = size_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      rdata_d     = rdata_q;
      err_d       = err_q;
      last_addr_d = last_addr_q;
      bus_en_d    = bus_en_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_size_d  = bus_size_q;
      bus_be_d    = bus_be_q;
      bus_st_d    = bus_st_q;
      case (state_q)
         IDLE: begin
            if (pick_f || pick_ls) begin
               owner_d     = pick_f ? OWN_FETCH : OWN_LS;
               size_d      = sel_size;
               off_d       = sel_off;
               last_addr_d = sel_addr;
               cnt_d       = '0;
               if (req_mis) begin
                  state_d = RESP;
                  err_d   = 1'b1;
                  rdata_d = '0;
               end else begin
                  state_d    = BUSY;
                  bus_en_d   = 1'b1;
                  bus_we_d   = sel_we;
                  bus_addr_d = {sel_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                  bus_size_d = sel_size;
                  bus_be_d   = req_be;
                  bus_st_d   = req_st;
               end
            end
         end
         BUSY: begin
            if (bif.i_bus_ready || ((TIMEOUT_CYCLES != 0) &&
                                    (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)))) begin
               state_d    = RESP;
               err_d      = !bif.i_bus_ready;
               rdata_d    = bif.i_bus_ready ? rsp_ld : '0;
               bus_en_d   = 1'b0;
               bus_we_d   = 1'b0;
               bus_addr_d = '0;
               bus_size_d = '0;
               bus_be_d   = '0;
               bus_st_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            state_d = IDLE;
            rr_d    = (owner_q == OWN_FETCH) ? OWN_LS : OWN_FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         owner_q     <= OWN_FETCH;
         rr_q        <= OWN_FETCH;
         size_q      <= '0;
         off_q       <= '0;
         cnt_q       <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         last_addr_q <= '0;
         bus_en_q    <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_size_q  <= '0;
         bus_be_q    <= '0;
         bus_st_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_q        <= rr_d;
         size_q      <= size_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         rdata_q     <= rdata_d;
         err_q       <= err_d;
         last_addr_q <= last_addr_d;
         bus_en_q    <= bus_en_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_size_q  <= bus_size_d;
         bus_be_q    <= bus_be_d;
         bus_st_q    <= bus_st_d;
      end
   end

   assign bif.f_gnt         = (state_q == IDLE) && pick_f;
   assign bif.ls_gnt        = (state_q == IDLE) && pick_ls;
   assign bif.f_rvalid      = (state_q == RESP) && (owner_q == OWN_FETCH);
   assign bif.ls_rvalid     = (state_q == RESP) && (owner_q == OWN_LS);
   assign bif.f_rdata       = bif.f_rvalid ? rdata_q : '0;
   assign bif.ls_rdata      = bif.ls_rvalid ? rdata_q : '0;
   assign bif.f_err         = bif.f_rvalid && err_q;
   assign bif.ls_err        = bif.ls_rvalid && err_q;
   assign bif.o_last_addr   = last_addr_q;
   assign bif.o_bus_en      = bus_en_q;
   assign bif.o_bus_we      = bus_we_q;
   assign bif.o_bus_addr    = bus_addr_q;
   assign bif.o_bus_size    = bus_size_q;
   assign bif.o_bus_be      = bus_be_q;
   assign bif.o_bus_st_data = bus_st_q;
endmodule

// File: doc/bus_arb_ctrl.md
Name: bus_arb_ctrl

Overview:
Parametrised successor to the single-path bus controller. Two requesters, instruction fetch and load/store, share one external pad bus through a round-robin or fixed-priority arbiter. Adds byte-lane enables, a misalignment check, a transaction timeout and error responses. Sits between the core's fetch/LSU units and the pad interface; one transaction outstanding at a time.

Parameters:
DATA_WIDTH, 32, bus data width; legal values are 32 and 64.
ADDR_WIDTH, 16, byte address width.
TIMEOUT_CYCLES, 255, maximum cycles in BUSY before an error response; 0 disables the timeout.
FETCH_PRIO, 0, 1 gives fetch fixed priority; 0 selects round-robin.

Ports:
clk_i  in  1  clock
reset_n  in  1  asynchronous, active-low reset
ld_on_rst  in  1  init-load mode; blocks fetch grants
f_req  in  1  fetch request
f_addr  in  ADDR_WIDTH  fetch address; always full-width access
f_gnt  out  1  fetch request accepted (combinational, IDLE only)
f_rvalid  out  1  fetch response pulse
f_rdata  out  DATA_WIDTH  fetch data
f_err  out  1  fetch error, qualified by f_rvalid
ls_req  in  1  load/store request
ls_we  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (only when DATA_WIDTH=64)
ls_addr  in  ADDR_WIDTH  byte address
ls_wdata  in  DATA_WIDTH  store data, right-aligned
ls_gnt  out  1  load/store request accepted
ls_rvalid  out  1  load/store response pulse; also issued for stores
ls_rdata  out  DATA_WIDTH  load data, right-aligned, zero-extended
ls_err  out  1  load/store error, qualified by ls_rvalid
o_last_addr  out  ADDR_WIDTH  address of the last accepted request (used by the init controller)
o_bus_en, o_bus_we  out  1  pad bus strobes
o_bus_addr  out  ADDR_WIDTH  word-aligned pad address
o_bus_size  out  2  access size
o_bus_be  out  DATA_WIDTH/8  byte enables
o_bus_st_data  out  DATA_WIDTH  lane-replicated store data
i_bus_ready  in  1  pad bus completion
i_bus_ld_data  in  DATA_WIDTH  pad read data, sampled when i_bus_ready=1 in BUSY

Behaviour:
- Reset: every output is 0; state is IDLE; the round-robin pointer points at fetch (fetch wins the first tie).
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - Eligible requests are ls_req, and f_req only when ld_on_rst=0.
  - Winner selection: FETCH_PRIO=1 always picks fetch; otherwise the channel not served last wins a tie.
  - The winner's gnt=1 in the same cycle. Address, we, size and data are registered, and o_last_addr is updated.
  - Legal request -> BUSY. Illegal request -> RESP with err=1; no bus access is made.
- Illegal requests: half with addr[0]=1; word with addr[1:0]!=0; dword with addr[2:0]!=0; size 3 when DATA_WIDTH=32.
- BUSY:
  - o_bus_en=1 and o_bus_we=stored we.
  - o_bus_addr = stored address with its low log2(DATA_WIDTH/8) bits cleared.
  - o_bus_be/o_bus_st_data come from the lane aligner.
  - All bus outputs are registered and held stable until exit.
  - i_bus_ready=1: capture the aligned read data, go to RESP with err=0.
  - Timeout counter starts at 0 on entry and increments each cycle; reaching TIMEOUT_CYCLES (nonzero) -> RESP with err=1 and rdata=0.
  - Bus strobes drop to 0 on the cycle after exit.
- RESP:
  - The owner's rvalid=1 for exactly one cycle with rdata/err; the other channel's response outputs stay 0.
  - Round-robin pointer updates. Next state is IDLE; no grant is issued in RESP.
- Latency: request -> gnt 0 cycles; gnt -> o_bus_en 1 cycle; i_bus_ready -> rvalid 1 cycle. Minimum gnt-to-rvalid is 2 cycles; an error-without-bus response is 1 cycle.
- Lane rules, with off = addr byte offset:
  - Byte: be = 1<<off; store data = byte replicated to every lane; load = data>>(8*off) masked to 8 bits.
  - Half: be = 2'b11<<off; same replication/extraction scheme at 16 bits.
  - Word on a 64-bit bus: be = 4'hF<<off, 32-bit extraction.
  - Full width: all be bits set.
  - Fetch is always a full-width access with all be set.
- Requesters must hold req/addr stable until gnt. Deasserting req before gnt is legal: the request is simply not served.
- ld_on_rst rising while a fetch is in BUSY does not abort the fetch; it completes normally.
- Asynchronous reset mid-transaction returns to IDLE immediately; no rvalid is issued.
- i_bus_ready outside BUSY is ignored.

Decomposition:
- Package bus_pkg holds:
  - size encodings SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_DWORD=3;
  - state enum IDLE/BUSY/RESP;
  - owner encoding OWN_FETCH/OWN_LS.
- Sub-module bus_lane_align is purely combinational and is instantiated twice: size+offset -> be, store replication, load extraction, misalign flag.
- The top level holds the arbiter, FSM, timeout counter and registers.

Test Plan:
- Byte store: ls_we=1, size=0, addr=0x0013, wdata=0xA5 -> BUSY with o_bus_addr=0x0010, be=4'b1000, st_data=0xA5A5A5A5; ready after 2 cycles -> ls_rvalid 1 cycle, ls_err=0.
- Half load: addr=0x0022, i_bus_ld_data=0xBEEF1234 -> be=4'b1100, ls_rdata=0x0000BEEF.
- Round-robin: f_req and ls_req held high together -> grants alternate F, LS, F, LS. FETCH_PRIO=1 -> fetch granted every time.
- ld_on_rst=1 with both requests high -> only ls_gnt pulses; fetch is granted on the first IDLE after ld_on_rst drops.
- Misaligned word: addr=0x0006 -> ls_gnt, then ls_rvalid+ls_err on the next cycle; o_bus_en never asserts.
- Timeout: TIMEOUT_CYCLES=4, i_bus_ready held 0 -> err response 5 cycles after gnt with rdata=0; a reset_n pulse mid-BUSY -> all outputs 0, no rvalid.
